// File: rtl/matissa_mult_pipe_if.sv
// Handshake bundle for the pipelined mantissa multiplier: operation in, product out.
interface matissa_mult_pipe_if #(
  parameter int unsigned W     = 28,
  parameter int unsigned TAG_W = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   out_prod;
  logic [1:0]       out_op;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_prod, out_op, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_prod, out_op, out_tag
  );
endinterface

// File: rtl/matissa_mult_pipe.sv
// Three-stage elastic mantissa multiplier: one WxW, two (W/2)^2 or four (W/4)^2 products.
module matissa_mult_pipe #(
  parameter int unsigned W     = 28,
  parameter int unsigned TAG_W = 4
) (
  input  logic clk,
  input  logic rst,
  matissa_mult_pipe_if.slave bus
);
  localparam int unsigned PW = 2 * W;
  localparam int unsigned H  = W / 2;
  localparam int unsigned Q  = W / 4;

  typedef logic [PW-1:0] row_t;
  typedef struct packed { row_t s; row_t c; } cs_t;

  // Positions where a carry entering that bit would cross a lane boundary.
  function automatic row_t brk_mask(input logic [1:0] op);
    row_t m;
    m = '0;
    if (op == 2'b10) begin
      m[W] = 1'b1;
    end else if (op == 2'b11) begin
      m[2*Q]   = 1'b1;
      m[W]     = 1'b1;
      m[W+2*Q] = 1'b1;
    end
    return m;
  endfunction

  function automatic int unsigned lane_of(input int unsigned p, input logic [1:0] op);
    if (op == 2'b11) return p / Q;
    if (op == 2'b10) return p / H;
    return 0;
  endfunction

  // Row j of the shared array; a-bits outside b-bit j's lane are gated off,
  // which removes exactly the cross products of the split modes.
  function automatic row_t pp_row(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [1:0] op, input int unsigned j);
    logic [W-1:0] am;
    for (int unsigned p = 0; p < W; p++)
      am[p] = a[p] & (lane_of(p, op) == lane_of(j, op));
    if (b[j]) return row_t'(am) << j;
    return '0;
  endfunction

  // 3:2 compressor; carries leaving a lane are dropped so each lane's
  // redundant pair stays exact modulo its own field width.
  function automatic cs_t csa(input row_t x, input row_t y, input row_t z, input row_t brk);
    cs_t r;
    r.s = x ^ y ^ z;
    r.c = ((x & y) | (x & z) | (y & z)) << 1;
    r.c = r.c & ~brk;
    return r;
  endfunction

  logic             v1, v2, v3;
  logic [1:0]       op1, op2, op3;
  logic [TAG_W-1:0] tag1, tag2, tag3;
  row_t             sa1, ca1, sb1, cb1;
  row_t             s2, c2;
  row_t             prod3;
  cs_t              acc_a, acc_b, t1, t2;
  row_t             sum3;
  logic             load1, load2, load3;

  // Elastic advance: a stage loads when empty or when its successor loads.
  always_comb begin
    load3 = !v3 || bus.out_ready;
    load2 = !v2 || load3;
    load1 = !v1 || load2;
  end

  assign bus.in_ready  = load1;
  assign bus.out_valid = v3;
  assign bus.out_prod  = prod3;
  assign bus.out_op    = op3;
  assign bus.out_tag   = tag3;

  // S1 combinational: partial products, lower and upper halves compressed separately.
  always_comb begin
    acc_a = '0;
    acc_b = '0;
    for (int unsigned j = 0; j < H; j++)
      acc_a = csa(acc_a.s, acc_a.c, pp_row(bus.in_a, bus.in_b, bus.in_op, j), brk_mask(bus.in_op));
    for (int unsigned j = H; j < W; j++)
      acc_b = csa(acc_b.s, acc_b.c, pp_row(bus.in_a, bus.in_b, bus.in_op, j), brk_mask(bus.in_op));
  end

  // S2 combinational: merge the four redundant rows down to two.
  always_comb begin
    t1 = csa(sa1, ca1, sb1, brk_mask(op1));
    t2 = csa(t1.s, t1.c, cb1, brk_mask(op1));
  end

  // S3 combinational: ripple carry-propagate add with mode-dependent chain breaks.
  always_comb begin
    logic carry;
    row_t brk;
    carry = 1'b0;
    brk   = brk_mask(op2);
    sum3  = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      if (brk[i]) carry = 1'b0;
      sum3[i] = s2[i] ^ c2[i] ^ carry;
      carry   = (s2[i] & c2[i]) | (s2[i] & carry) | (c2[i] & carry);
    end
  end

  // Stage valid flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (load1) v1 <= bus.in_valid;
      if (load2) v2 <= v1;
      if (load3) v3 <= v2;
    end
  end

  // S1 register: operands sampled only on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa1 <= '0; ca1 <= '0; sb1 <= '0; cb1 <= '0; op1 <= '0; tag1 <= '0;
    end else if (load1 && bus.in_valid) begin
      sa1 <= acc_a.s; ca1 <= acc_a.c; sb1 <= acc_b.s; cb1 <= acc_b.c;
      op1 <= bus.in_op; tag1 <= bus.in_tag;
    end
  end

  // S2 register: two-row redundant product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2 <= '0; c2 <= '0; op2 <= '0; tag2 <= '0;
    end else if (load2 && v1) begin
      s2 <= t2.s; c2 <= t2.c; op2 <= op1; tag2 <= tag1;
    end
  end

  // S3 output register: holds while stalled downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod3 <= '0; op3 <= '0; tag3 <= '0;
    end else if (load3 && v2) begin
      prod3 <= sum3; op3 <= op2; tag3 <= tag2;
    end
  end
endmodule

// File: tb/tb_matissa_mult_pipe.sv
// Scoreboard bench for matissa_mult_pipe at W=28, TAG_W=4.
module tb_matissa_mult_pipe;
  localparam int unsigned W = 28;
  localparam int unsigned T = 4;

  typedef struct {
    logic [2*W-1:0] prod;
    logic [1:0]     op;
    logic [T-1:0]   tag;
    int             cyc;
    bit             lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   nchk = 0, nfail = 0;
  int   npush = 0, npop = 0, nflushed = 0;
  exp_t q[$];

  matissa_mult_pipe_if #(.W(W), .TAG_W(T)) bus ();
  matissa_mult_pipe #(.W(W), .TAG_W(T)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference products from plain per-lane arithmetic.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] op);
    logic [2*W-1:0] r;
    if (!op[1]) begin
      r = (2*W)'(a) * (2*W)'(b);
    end else if (op == 2'b10) begin
      r = {28'(a[27:14]) * 28'(b[27:14]), 28'(a[13:0]) * 28'(b[13:0])};
    end else begin
      r = '0;
      for (int k = 0; k < 4; k++)
        r[k*14 +: 14] = 14'(a[k*7 +: 7]) * 14'(b[k*7 +: 7]);
    end
    return r;
  endfunction

  // Monitor: pops on every output transfer, checks hold stability while stalled.
  initial begin
    bit             prev_stall = 0;
    logic [2*W-1:0] pp;
    logic [1:0]     po;
    logic [T-1:0]   pt;
    exp_t           e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 64'(bus.out_valid), 64'd1);
          chk("hold_prod", 64'(bus.out_prod), 64'(pp));
          chk("hold_optag", 64'({bus.out_op, bus.out_tag}), 64'({po, pt}));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 64'(bus.out_prod), 64'hDEAD);
          end else begin
            e = q.pop_front();
            npop++;
            chk("prod", 64'(bus.out_prod), 64'(e.prod));
            chk("op", 64'(bus.out_op), 64'(e.op));
            chk("tag", 64'(bus.out_tag), 64'(e.tag));
            if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd3);
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        pp = bus.out_prod; po = bus.out_op; pt = bus.out_tag;
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                      input logic [T-1:0] tag, input logic [2*W-1:0] expv, input bit lat);
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_op = op; bus.in_tag = tag;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back('{expv, op, tag, cyc, lat});
        npush++;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("accept_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  // One cycle of random stimulus; pushes the model result when accepted.
  task automatic rand_cycle(input bit valid, output bit fired);
    bus.in_valid = valid;
    bus.in_a = W'($urandom); bus.in_b = W'($urandom);
    bus.in_op = 2'($urandom_range(0, 3)); bus.in_tag = T'($urandom);
    @(negedge clk);
    fired = bus.in_valid && bus.in_ready;
    if (fired) begin
      q.push_back('{model(bus.in_a, bus.in_b, bus.in_op), bus.in_op, bus.in_tag, cyc, 1'b0});
      npush++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bit fired;
    int acc, guard;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = '0; bus.in_tag = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_prod", 64'(bus.out_prod), 64'd0);
    chk("rst_out_optag", 64'({bus.out_op, bus.out_tag}), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed products with latency checking.
    bus.out_ready = 1'b1;
    send(28'hFFFFFFF, 28'hFFFFFFF, 2'b00, 4'h5, 56'hFFFFFFE0000001, 1'b1);
    send(28'hFFFFFFF, 28'hFFFFFFF, 2'b10, 4'h6, 56'hFFF8001FFF8001, 1'b1);
    send(28'hFFFFFFF, 28'hFFFFFFF, 2'b11, 4'h7, {4{14'h3F01}}, 1'b1);
    send({7'h01, 7'h00, 7'h7F, 7'h02}, {7'h01, 7'h00, 7'h7F, 7'h02}, 2'b11, 4'h8,
         {14'h0001, 14'h0000, 14'h3F01, 14'h0004}, 1'b1);
    send(28'h1234567, 28'h0ABCDEF, 2'b01, 4'h9, model(28'h1234567, 28'h0ABCDEF, 2'b01), 1'b1);
    drain(50);

    // Back-pressure: fill with output stalled, then release.
    bus.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      rand_cycle(1'b1, fired);
      if (fired) acc++;
    end
    chk("bp_accepts", 64'(acc), 64'd3);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    guard = 0;
    while (acc < 10 && guard < 100) begin
      rand_cycle(1'b1, fired);
      if (fired) acc++;
      guard++;
    end
    bus.in_valid = 1'b0;
    drain(50);

    // Random handshake traffic.
    acc = 0; guard = 0;
    while (acc < 10000 && guard < 60000) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rand_cycle($urandom_range(0, 3) != 0, fired);
      if (fired) acc++;
      guard++;
    end
    chk("rand_accepts", 64'(acc), 64'd10000);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain(100);

    // Reset with two operations in flight.
    send(28'h0000003, 28'h0000005, 2'b00, 4'hA, 56'd15, 1'b1);
    send(28'h0000007, 28'h0000009, 2'b00, 4'hB, 56'd63, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    nflushed += q.size();
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("postrst_in_ready", 64'(bus.in_ready), 64'd1);
    send(28'h00000FF, 28'h0000101, 2'b00, 4'hC, 56'h0FFFF, 1'b1);
    drain(50);
    repeat (6) @(posedge clk);
    #1;
    chk("count", 64'(npop), 64'(npush - nflushed));

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
